sram_bank_bridge: RTL and testbench
===================================

# sram_bank_bridge

Bridge between the AVR core data-bus (ramre/ramwe/ramadr) and one or more synchronous single-port SRAM macros. It replaces the fixed single-macro glue: ce_N/we_N gating, subtract-256 address and inverted macro clock. It adds a parametrised base address, bank count, bank depth and macro read latency. Read wait states are inserted through a core stall handshake. Macros are clocked on clk rising edge, and the bridge sits between the core and the data-memory macros at the top level.

## Interface
- ADDR_W, 12: core data-address width.
- DATA_W, 8: data width.
- BASE, 256: first core address mapped to SRAM (below this: register file / IO space).
- BANK_AW, 8: address bits per bank (bank depth 2^BANK_AW).
- NUM_BANKS, 2: number of macros; BASE + NUM_BANKS*2^BANK_AW <= 2^ADDR_W.
- RD_LAT, 1: macro read latency in clk edges, 1..4.

- clk  in  1  clock; macros sample on rising edge.
- ireset  in  1  reset, asynchronous, active-high.
- core_re  in  1  read request; held by core while core_stall=1.
- core_we  in  1  write request, single cycle.
- core_adr  in  ADDR_W  byte address.
- core_dout  in  DATA_W  write data from core.
- core_din  out  DATA_W  read data to core.
- core_stall  out  1  wait request to core.
- hit  out  1  core_adr within SRAM window.
- sram_cen  out  NUM_BANKS  per-bank chip enable, active-low.
- sram_wen  out  1  write enable, active-low, shared.
- sram_a  out  BANK_AW  macro address, shared.
- sram_d  out  DATA_W  macro write data, shared (= core_dout).
- sram_q  in  NUM_BANKS*DATA_W  macro read data; bank b at [b*DATA_W +: DATA_W].

## Operation
- Decode (combinational): off = core_adr - BASE.
  - hit = (core_adr >= BASE) && (off < NUM_BANKS<<BANK_AW).
  - bank = off >> BANK_AW.
  - sram_a = off[BANK_AW-1:0] in IDLE, latched address otherwise.
- FSM states IDLE, RWAIT, RDATA. Registers: state, cnt, latched bank/address, rdata_q.
- IDLE, write (core_we & hit):
  - sram_cen[bank]=0, sram_wen=0, core_stall=0; stay IDLE.
  - Posted write, one per cycle sustained.
- IDLE, read (core_re & hit & !core_we):
  - sram_cen[bank]=0, sram_wen=1, core_stall=1.
  - Latch bank/address.
  - Next state RDATA if RD_LAT=1, else RWAIT with cnt=RD_LAT-2.
- Simultaneous core_re & core_we: treated as a write; the read is dropped.
- RWAIT: all sram_cen=1, core_stall=1. Decrement cnt; at cnt=0 go RDATA.
- RDATA:
  - All sram_cen=1, core_stall=0.
  - core_din = sram_q slice of latched bank; same value captured into rdata_q.
  - Go IDLE. The core's still-asserted core_re in this cycle does not start a new access.
- Outside RDATA: core_din = rdata_q (holds last read data).
- Miss (hit=0) or no request: all sram_cen=1, sram_wen=1, core_stall=0, no state change.
- Reads are not abortable. Deassertion of core_re in RWAIT still completes through RDATA. Only ireset aborts.

## Timing
- Reset values (while ireset=1 and after):
  - state=IDLE, rdata_q=0, core_din=0, core_stall=0.
  - sram_cen all 1, sram_wen=1, overriding request inputs.
- Read issued in cycle T:
  - core_stall=1 in cycles T..T+RD_LAT-1.
  - Data valid on core_din with core_stall=0 in cycle T+RD_LAT.
  - Next request accepted at T+RD_LAT+1.
  - Read throughput is one per RD_LAT+1 cycles.
- Write: zero wait states. Macro samples at the end of the request cycle. A read of the same address issued the next cycle returns the new data.
- Reset asserted mid-read: outputs take reset values immediately (asynchronous). rdata_q is cleared. The pending read is discarded.
- Address boundaries:
  - BASE-1 is a miss.
  - BASE maps to bank 0, a=0.
  - BASE + NUM_BANKS*2^BANK_AW - 1 maps to last bank, a=all-ones.
  - One above that is a miss.

## Test plan
Parameters unless noted: BASE=256, BANK_AW=8, NUM_BANKS=4, RD_LAT=2.

- Write 0xA5 to 0x100 -> same cycle sram_cen=4'b1110, sram_wen=0, sram_a=0x00, sram_d=0xA5, core_stall=0.
- Read 0x100 next cycle -> core_stall=1 for 2 cycles; third cycle core_din=0xA5, core_stall=0; core_din stays 0xA5 afterward.
- Write 0x3C to 0x4FF, then read it -> sram_cen=4'b0111, sram_a=0xFF; readback 0x3C.
- Read 0x0FF and 0x500 -> hit=0, sram_cen=4'b1111, core_stall=0, core_din unchanged.
- core_re=core_we=1 at 0x200 with data 0x11 -> write to bank 1, a=0x00, no stall. Then ireset asserted during RWAIT of a read -> instantly sram_cen=4'b1111, core_stall=0, core_din=0; a post-reset read completes normally.
- RD_LAT=1, NUM_BANKS=2, back-to-back reads 0x100 then 0x2FF -> each 1 stall cycle; data returned at T+1 and T+3.

Source files
------------

// File: rtl/sram_bank_bridge.sv
// rtl/sram_bank_bridge.sv - AVR data-bus to banked synchronous single-port SRAM bridge
module sram_bank_bridge #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int BASE      = 256,
    parameter int BANK_AW   = 8,
    parameter int NUM_BANKS = 2,
    parameter int RD_LAT    = 1
) (
    input  logic                        clk,
    input  logic                        ireset,
    input  logic                        core_re,
    input  logic                        core_we,
    input  logic [ADDR_W-1:0]           core_adr,
    input  logic [DATA_W-1:0]           core_dout,
    output logic [DATA_W-1:0]           core_din,
    output logic                        core_stall,
    output logic                        hit,
    output logic [NUM_BANKS-1:0]        sram_cen,
    output logic                        sram_wen,
    output logic [BANK_AW-1:0]          sram_a,
    output logic [DATA_W-1:0]           sram_d,
    input  logic [NUM_BANKS*DATA_W-1:0] sram_q
);

    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
    // Widened by one bit so a window that fills the whole address space still compares correctly.
    localparam logic [ADDR_W:0]   NB_LIM = (ADDR_W + 1)'(NUM_BANKS);
    // Cycles spent in RWAIT minus one; unused when the macro answers after a single edge.
    localparam logic [1:0]        CNT_INIT = 2'((RD_LAT > 1) ? RD_LAT - 2 : 0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RWAIT = 2'd1;
    localparam logic [1:0] ST_RDATA = 2'd2;

    logic [1:0]         state;
    logic [1:0]         cnt;
    logic [BANK_W-1:0]  lat_bank;
    logic [BANK_AW-1:0] lat_a;
    logic [DATA_W-1:0]  rdata_q;

    logic [ADDR_W-1:0]  off;
    logic [ADDR_W-1:0]  off_shift;
    logic [BANK_W-1:0]  bank;
    logic [DATA_W-1:0]  q_sel;
    logic               idle;
    logic               wr_go;
    logic               rd_go;

    // Window decode: offset from BASE, bank index from the bits above the bank depth.
    always_comb begin
        off       = core_adr - BASE_A;
        off_shift = off >> BANK_AW;
        hit       = (core_adr >= BASE_A) && ({1'b0, off_shift} < NB_LIM);
        bank      = off_shift[BANK_W-1:0];
    end

    // Requests are only taken in IDLE and never while reset is asserted; a write wins over a read.
    always_comb begin
        idle  = (state == ST_IDLE);
        wr_go = !ireset && idle && core_we && hit;
        rd_go = !ireset && idle && core_re && !core_we && hit;
    end

    // Read-data select from the bank latched when the read was issued.
    always_comb begin
        q_sel = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (lat_bank == BANK_W'(b)) begin
                q_sel = sram_q[b*DATA_W +: DATA_W];
            end
        end
    end

    // Macro strobes: one bank enabled only in the cycle a request is accepted.
    always_comb begin
        sram_cen = '1;
        if (wr_go || rd_go) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (bank == BANK_W'(b)) begin
                    sram_cen[b] = 1'b0;
                end
            end
        end
    end

    // Shared macro bus, stall and read-data return to the core.
    always_comb begin
        sram_wen   = !wr_go;
        sram_d     = core_dout;
        sram_a     = idle ? off[BANK_AW-1:0] : lat_a;
        core_stall = !ireset && (rd_go || (state == ST_RWAIT));
        core_din   = (state == ST_RDATA) ? q_sel : rdata_q;
    end

    // Read sequencer: issue, wait out the macro latency, return data once, then back to IDLE.
    always_ff @(posedge clk or posedge ireset) begin
        if (ireset) begin
            state    <= ST_IDLE;
            cnt      <= 2'd0;
            lat_bank <= '0;
            lat_a    <= '0;
            rdata_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rd_go) begin
                        lat_bank <= bank;
                        lat_a    <= off[BANK_AW-1:0];
                        if (RD_LAT == 1) begin
                            state <= ST_RDATA;
                        end else begin
                            state <= ST_RWAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                ST_RWAIT: begin
                    if (cnt == 2'd0) begin
                        state <= ST_RDATA;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                ST_RDATA: begin
                    rdata_q <= q_sel;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bank_bridge.sv
// tb/tb_sram_bank_bridge.sv - self-checking bench for sram_bank_bridge (two parameter sets)
module tb_sram_bank_bridge;

    logic clk;
    logic ireset;

    // Instance 0: 4 banks, read latency 2
    logic        re0, we0;
    logic [11:0] adr0;
    logic [7:0]  dout0, din0, a0, d0;
    logic        stall0, hit0, wen0;
    logic [3:0]  cen0;
    logic [31:0] q0;

    // Instance 1: 2 banks, read latency 1
    logic        re1, we1;
    logic [11:0] adr1;
    logic [7:0]  dout1, din1, a1, d1;
    logic        stall1, hit1, wen1;
    logic [1:0]  cen1;
    logic [15:0] q1;

    int vectors = 0;
    int miscompares = 0;

    sram_bank_bridge #(.ADDR_W(12), .DATA_W(8), .BASE(256), .BANK_AW(8), .NUM_BANKS(4), .RD_LAT(2)) u_dut0 (
        .clk(clk), .ireset(ireset), .core_re(re0), .core_we(we0), .core_adr(adr0),
        .core_dout(dout0), .core_din(din0), .core_stall(stall0), .hit(hit0),
        .sram_cen(cen0), .sram_wen(wen0), .sram_a(a0), .sram_d(d0), .sram_q(q0)
    );

    sram_bank_bridge #(.ADDR_W(12), .DATA_W(8), .BASE(256), .BANK_AW(8), .NUM_BANKS(2), .RD_LAT(1)) u_dut1 (
        .clk(clk), .ireset(ireset), .core_re(re1), .core_we(we1), .core_adr(adr1),
        .core_dout(dout1), .core_din(din1), .core_stall(stall1), .hit(hit1),
        .sram_cen(cen1), .sram_wen(wen1), .sram_a(a1), .sram_d(d1), .sram_q(q1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro models: sample on rising edge, data appears after RD_LAT edges and then holds.
    logic [7:0] mem0 [0:3][0:255];
    logic [7:0] p0a [0:3];
    logic [7:0] p0b [0:3];
    logic [7:0] mem1 [0:1][0:255];
    logic [7:0] p1a [0:1];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (!cen0[b]) begin
                if (!wen0) mem0[b][a0] <= d0;
                else       p0a[b] <= mem0[b][a0];
            end
            p0b[b] <= p0a[b];
        end
        for (int b = 0; b < 2; b++) begin
            if (!cen1[b]) begin
                if (!wen1) mem1[b][a1] <= d1;
                else       p1a[b] <= mem1[b][a1];
            end
        end
    end

    always_comb begin
        for (int b = 0; b < 4; b++) q0[b*8 +: 8] = p0b[b];
        for (int b = 0; b < 2; b++) q1[b*8 +: 8] = p1a[b];
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: a read issued in cycle c stalls until c+lat-1 and returns
    // the shadow-memory byte in cycle c+lat; a hit write updates the shadow memory.
    int         cyc = 0;
    int         lat [2] = '{2, 1};
    int         nb  [2] = '{4, 2};
    logic [7:0] sh [0:1][0:3][0:255];
    bit         busy [2] = '{0, 0};
    int         issue [2];
    int         rb [2];
    int         ra [2];
    logic [7:0] last [2] = '{8'h00, 8'h00};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int adr, off, ebank, ea, k;
            logic re, we, ehit, ewen, estall, chk_a;
            logic [3:0] ecen, acen;
            logic [7:0] dout, edin;
            re   = (i == 0) ? re0 : re1;
            we   = (i == 0) ? we0 : we1;
            adr  = (i == 0) ? int'(adr0) : int'(adr1);
            dout = (i == 0) ? dout0 : dout1;
            acen = (i == 0) ? cen0 : {2'b11, cen1};
            off   = adr - 256;
            ehit  = (adr >= 256) && (adr < 256 + nb[i] * 256);
            ebank = off / 256;
            ea    = off % 256;
            ecen = 4'hF; ewen = 1'b1; estall = 1'b0; edin = last[i]; chk_a = 1'b0;
            if (ireset) begin
                busy[i] = 0;
                last[i] = 8'h00;
                edin    = 8'h00;
            end else if (busy[i]) begin
                k = cyc - issue[i];
                if (k < lat[i]) begin
                    estall = 1'b1;
                end else begin
                    edin    = sh[i][rb[i]][ra[i]];
                    last[i] = edin;
                    busy[i] = 0;
                end
            end else if (ehit && we) begin
                ecen[ebank] = 1'b0;
                ewen  = 1'b0;
                chk_a = 1'b1;
                sh[i][ebank][ea] = dout;
            end else if (ehit && re) begin
                ecen[ebank] = 1'b0;
                estall   = 1'b1;
                chk_a    = 1'b1;
                busy[i]  = 1;
                issue[i] = cyc;
                rb[i]    = ebank;
                ra[i]    = ea;
            end
            cmp($sformatf("u%0d hit", i),   32'((i == 0) ? hit0 : hit1),     32'(ehit));
            cmp($sformatf("u%0d cen", i),   32'(acen),                       32'(ecen));
            cmp($sformatf("u%0d wen", i),   32'((i == 0) ? wen0 : wen1),     32'(ewen));
            cmp($sformatf("u%0d stall", i), 32'((i == 0) ? stall0 : stall1), 32'(estall));
            cmp($sformatf("u%0d din", i),   32'((i == 0) ? din0 : din1),     32'(edin));
            if (chk_a) begin
                cmp($sformatf("u%0d sram_a", i), 32'((i == 0) ? a0 : a1), 32'(ea));
                cmp($sformatf("u%0d sram_d", i), 32'((i == 0) ? d0 : d1), 32'(dout));
            end
        end
        cyc++;
    end

    task automatic drive(input int i, input logic re, input logic we, input logic [11:0] adr, input logic [7:0] dout);
        @(posedge clk);
        #1;
        if (i == 0) begin re0 = re; we0 = we; adr0 = adr; dout0 = dout; end
        else        begin re1 = re; we1 = we; adr1 = adr; dout1 = dout; end
        @(negedge clk);
    endtask

    task automatic do_read(input int i, input logic [11:0] adr, output int stalls, output logic [7:0] data);
        @(posedge clk);
        #1;
        if (i == 0) begin re0 = 1'b1; we0 = 1'b0; adr0 = adr; end
        else        begin re1 = 1'b1; we1 = 1'b0; adr1 = adr; end
        stalls = 0;
        @(negedge clk);
        while (((i == 0) ? stall0 : stall1) && stalls < 16) begin
            stalls++;
            @(negedge clk);
        end
        data = (i == 0) ? din0 : din1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int         st;
        logic [7:0] dv;
        time        t1, t2;

        // Reset with a request already on the bus: strobes must stay inactive.
        ireset = 1'b1;
        re0 = 1'b1; we0 = 1'b1; adr0 = 12'h100; dout0 = 8'h77;
        re1 = 1'b0; we1 = 1'b0; adr1 = 12'h000; dout1 = 8'h00;
        @(negedge clk);
        cmp("reset cen",   32'(cen0),   'hF);
        cmp("reset wen",   32'(wen0),   1);
        cmp("reset stall", 32'(stall0), 0);
        cmp("reset din",   32'(din0),   0);
        @(posedge clk);
        #1;
        ireset = 1'b0; re0 = 1'b0; we0 = 1'b0;
        drive(0, 0, 0, 12'h000, 8'h00);

        // Posted write to the first SRAM byte.
        drive(0, 0, 1, 12'h100, 8'hA5);
        cmp("wr100 cen",   32'(cen0),   'hE);
        cmp("wr100 wen",   32'(wen0),   0);
        cmp("wr100 a",     32'(a0),     'h00);
        cmp("wr100 d",     32'(d0),     'hA5);
        cmp("wr100 stall", 32'(stall0), 0);

        do_read(0, 12'h100, st, dv);
        cmp("rd100 stalls", 32'(st), 2);
        cmp("rd100 data",   32'(dv), 'hA5);
        drive(0, 0, 0, 12'h000, 8'h00);
        cmp("rd100 hold", 32'(din0), 'hA5);

        // Last byte of the last bank.
        drive(0, 0, 1, 12'h4FF, 8'h3C);
        cmp("wr4FF cen", 32'(cen0), 'h7);
        cmp("wr4FF a",   32'(a0),   'hFF);
        do_read(0, 12'h4FF, st, dv);
        cmp("rd4FF stalls", 32'(st), 2);
        cmp("rd4FF data",   32'(dv), 'h3C);

        // One below and one above the window.
        drive(0, 1, 0, 12'h0FF, 8'h00);
        cmp("rd0FF hit",   32'(hit0),   0);
        cmp("rd0FF cen",   32'(cen0),   'hF);
        cmp("rd0FF stall", 32'(stall0), 0);
        cmp("rd0FF din",   32'(din0),   'h3C);
        drive(0, 1, 0, 12'h500, 8'h00);
        cmp("rd500 hit",   32'(hit0),   0);
        cmp("rd500 cen",   32'(cen0),   'hF);
        cmp("rd500 stall", 32'(stall0), 0);

        // Read and write together: write wins.
        drive(0, 1, 1, 12'h200, 8'h11);
        cmp("rw200 cen",   32'(cen0),   'hD);
        cmp("rw200 wen",   32'(wen0),   0);
        cmp("rw200 a",     32'(a0),     'h00);
        cmp("rw200 stall", 32'(stall0), 0);
        drive(0, 0, 0, 12'h000, 8'h00);

        // Reset in the middle of the RWAIT cycle of a read.
        drive(0, 1, 0, 12'h200, 8'h00);
        cmp("rd200 issue stall", 32'(stall0), 1);
        @(posedge clk);
        @(negedge clk);
        cmp("rd200 rwait stall", 32'(stall0), 1);
        #2;
        ireset = 1'b1;
        #1;
        cmp("midreset cen",   32'(cen0),   'hF);
        cmp("midreset stall", 32'(stall0), 0);
        cmp("midreset din",   32'(din0),   0);
        @(negedge clk);
        @(posedge clk);
        #1;
        ireset = 1'b0; re0 = 1'b0;
        @(negedge clk);
        do_read(0, 12'h200, st, dv);
        cmp("post-reset stalls", 32'(st), 2);
        cmp("post-reset data",   32'(dv), 'h11);
        drive(0, 0, 0, 12'h000, 8'h00);

        // Instance 1: sustained writes, then back-to-back single-wait reads.
        drive(1, 0, 1, 12'h100, 8'h5A);
        cmp("u1 wr100 cen", 32'(cen1), 'h2);
        drive(1, 0, 1, 12'h2FF, 8'hC3);
        cmp("u1 wr2FF cen", 32'(cen1), 'h1);
        cmp("u1 wr2FF a",   32'(a1),   'hFF);
        do_read(1, 12'h100, st, dv);
        t1 = $time;
        cmp("u1 rd100 stalls", 32'(st), 1);
        cmp("u1 rd100 data",   32'(dv), 'h5A);
        do_read(1, 12'h2FF, st, dv);
        t2 = $time;
        cmp("u1 rd2FF stalls", 32'(st), 1);
        cmp("u1 rd2FF data",   32'(dv), 'hC3);
        cmp("u1 b2b spacing",  32'(t2 - t1), 20);
        drive(1, 1, 0, 12'h300, 8'h00);
        cmp("u1 rd300 hit", 32'(hit1), 0);
        drive(1, 0, 0, 12'h000, 8'h00);
        cmp("u1 hold", 32'(din1), 'hC3);
        drive(1, 0, 0, 12'h000, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
